// File: rtl/nvram_port_ctrl.sv
// Port-B sequencer for the dual-port NVRAM: fill on reset, bulk load from host, bulk save to host.
// All RAM-side and host-side outputs are registered; busy is decoded from the state register.
module nvram_port_ctrl #(
  parameter int          ADDR_W         = 9,
  parameter logic [7:0]  FILL           = 8'hFF,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              start_save,
  input  logic              abort,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic [7:0]        sv_data,
  output logic              sv_valid,
  input  logic              sv_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_LOAD      = 3'd2,
    S_SAVE_RD   = 3'd3,
    S_SAVE_WAIT = 3'd4,
    S_SAVE_OUT  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam state_t          S_RESET  = CLEAR_ON_RESET ? S_INIT : S_IDLE;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     cnt, cnt_nxt, cnt_inc;
  logic [ADDR_W-1:0]   ram_addr_nxt;
  logic [7:0]          ram_din_nxt;
  logic                ram_we_nxt;
  logic                ld_ready_nxt;
  logic [7:0]          sv_data_nxt;
  logic                sv_valid_nxt;
  logic                done_nxt;
  logic                ld_acc, sv_acc, at_last;

  assign ld_acc  = ld_valid & ld_ready;
  assign sv_acc  = sv_valid & sv_ready;
  assign at_last = (cnt == CNT_LAST);
  assign cnt_inc = cnt + 1'b1;
  assign busy    = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_nxt;
  end

  // Next-state decode; abort beats a same-edge handshake
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:      if (cnt == CNT_FULL) state_nxt = S_IDLE;
      S_IDLE: begin
        if (start_load)      state_nxt = S_LOAD;
        else if (start_save) state_nxt = S_SAVE_RD;
      end
      S_LOAD: begin
        if (abort)                 state_nxt = S_IDLE;
        else if (ld_acc && at_last) state_nxt = S_IDLE;
      end
      S_SAVE_RD:   state_nxt = abort ? S_IDLE : S_SAVE_WAIT;
      S_SAVE_WAIT: state_nxt = abort ? S_IDLE : S_SAVE_OUT;
      S_SAVE_OUT: begin
        if (abort)       state_nxt = S_IDLE;
        else if (sv_acc) state_nxt = at_last ? S_IDLE : S_SAVE_RD;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs and byte counter
  always_comb begin
    cnt_nxt      = cnt;
    ram_addr_nxt = ram_addr;
    ram_din_nxt  = ram_din;
    ram_we_nxt   = 1'b0;
    ld_ready_nxt = 1'b0;
    sv_data_nxt  = sv_data;
    sv_valid_nxt = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      S_INIT: begin
        if (!cnt[ADDR_W]) begin
          ram_we_nxt   = 1'b1;
          ram_addr_nxt = cnt[ADDR_W-1:0];
          ram_din_nxt  = FILL;
          cnt_nxt      = cnt_inc;
        end
      end
      S_IDLE: begin
        if (start_load) begin
          cnt_nxt      = '0;
          ld_ready_nxt = 1'b1;
        end else if (start_save) begin
          cnt_nxt      = '0;
          ram_addr_nxt = '0;
        end
      end
      S_LOAD: begin
        ld_ready_nxt = !abort;
        if (!abort && ld_acc) begin
          ram_we_nxt   = 1'b1;
          ram_addr_nxt = cnt[ADDR_W-1:0];
          ram_din_nxt  = ld_data;
          cnt_nxt      = cnt_inc;
          if (at_last) begin
            ld_ready_nxt = 1'b0;
            done_nxt     = 1'b1;
          end
        end
      end
      S_SAVE_WAIT: begin
        if (!abort) begin
          sv_data_nxt  = ram_dout;
          sv_valid_nxt = 1'b1;
        end
      end
      S_SAVE_OUT: begin
        sv_valid_nxt = !abort;
        if (!abort && sv_acc) begin
          sv_valid_nxt = 1'b0;
          cnt_nxt      = cnt_inc;
          if (at_last) done_nxt = 1'b1;
          else         ram_addr_nxt = cnt_inc[ADDR_W-1:0];
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ram_addr <= '0;
      ram_din  <= FILL;
      ram_we   <= 1'b0;
      ld_ready <= 1'b0;
      sv_data  <= 8'h00;
      sv_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      ram_addr <= ram_addr_nxt;
      ram_din  <= ram_din_nxt;
      ram_we   <= ram_we_nxt;
      ld_ready <= ld_ready_nxt;
      sv_data  <= sv_data_nxt;
      sv_valid <= sv_valid_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: doc/nvram_port_ctrl.md
# nvram_port_ctrl

Sequencer that drives the B port of the 512-byte dual-port NVRAM. The game CPU keeps the A port. On reset it fills the RAM with a fill byte. On command it either loads a full image from a host byte stream into the RAM, or streams the full RAM contents back to the host for saving. The RAM B port is write-first with 1-cycle registered read data.

## Interface
Parameters:
- ADDR_W, 9, RAM address width; depth = 2^ADDR_W bytes.
- FILL, 8'hFF, byte written to every location during INIT.
- CLEAR_ON_RESET, 1, 1 = run INIT after reset, 0 = go straight to IDLE.

Ports:
- clk  in  1  single clock for block and RAM port B.
- rst_n  in  1  asynchronous, active-low reset.
- start_load  in  1  one-cycle command: begin host-to-RAM transfer.
- start_save  in  1  one-cycle command: begin RAM-to-host transfer.
- abort  in  1  cancel the current LOAD/SAVE.
- ld_data  in  8  host load byte.
- ld_valid  in  1  ld_data valid.
- ld_ready  out  1  block accepts ld_data.
- sv_data  out  8  save byte to host.
- sv_valid  out  1  sv_data valid.
- sv_ready  in  1  host accepts sv_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a LOAD or SAVE completes all 2^ADDR_W bytes.
- ram_addr  out  ADDR_W  RAM port B address (registered).
- ram_din  out  8  RAM port B write data (registered).
- ram_we  out  1  RAM port B write enable (registered).
- ram_dout  in  8  RAM port B read data, valid 1 cycle after address is sampled.

## Operation
- States: INIT, IDLE, LOAD, SAVE_RD, SAVE_WAIT, SAVE_OUT.
- cnt is an internal ADDR_W+1-bit byte counter.
- INIT:
  - Each edge writes FILL to ram_addr=cnt with ram_we=1, then cnt++.
  - Every location is written, 0 through 2^ADDR_W-1, with no off-by-one at the top address.
  - After the last write: ram_we=0, go to IDLE.
  - No done pulse for INIT.
- IDLE:
  - start_load → LOAD, cnt=0.
  - Else start_save → SAVE_RD, cnt=0, ram_addr<=0.
  - start_load wins if both are asserted.
  - Commands are ignored in every state except IDLE; abort in IDLE has no effect.
- LOAD:
  - ld_ready=1.
  - Each edge with ld_valid&ld_ready registers ram_we=1, ram_addr=cnt, ram_din=ld_data, then cnt++.
  - Cycles with ld_valid low register ram_we=0.
  - The edge that accepts byte 2^ADDR_W-1 also clears ld_ready, goes to IDLE and pulses done on the next cycle.
- SAVE:
  - SAVE_RD → SAVE_WAIT unconditionally; the RAM samples ram_addr on this edge.
  - SAVE_WAIT → SAVE_OUT; sv_data<=ram_dout, sv_valid<=1.
  - SAVE_OUT holds sv_data and sv_valid stable until sv_ready.
  - On accept: sv_valid<=0, cnt++, ram_addr<=cnt+1, go to SAVE_RD.
  - Accept of the last byte goes to IDLE with a done pulse instead.
  - ram_we=0 throughout SAVE.
- abort in LOAD or SAVE:
  - Next edge: IDLE, ld_ready=0, sv_valid=0, ram_we=0, no done pulse.
  - Bytes already written are kept.
  - abort wins over a handshake on the same edge; that byte is not written or counted.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). INIT reruns if CLEAR_ON_RESET=1.

## Timing
- Reset values:
  - ram_we=0, ram_addr=0, ram_din=FILL.
  - ld_ready=0, sv_valid=0, sv_data=0, done=0.
  - busy=CLEAR_ON_RESET.
- INIT:
  - First rising edge after rst_n rises: ram_we=1, ram_addr=0.
  - Edge 2^ADDR_W: ram_addr=2^ADDR_W-1.
  - Edge 2^ADDR_W+1: ram_we=0, busy=0.
- start_load sampled at edge N: ld_ready=1 after edge N.
- Load byte accepted at edge M: ram write strobe visible in cycle after M. Maximum rate is 1 byte/cycle.
- start_save at edge N: sv_valid=1 after edge N+2. With sv_ready held high, one byte every 3 cycles.
- done: high exactly one cycle, starting the cycle after the final accept edge; busy falls in the same cycle.
- sv_data must never change while sv_valid=1 and sv_ready=0.

## Test plan
- Reset release, CLEAR_ON_RESET=1, ADDR_W=9 → exactly 512 write strobes at addr 0..511, all with data 8'hFF. busy falls on cycle 513. No done pulse.
- start_load, then stream bytes i^8'h5A for i=0..511 with ld_valid randomly toggled → RAM holds i^8'h5A at every address. One done pulse. ld_ready=0 afterwards.
- Preloaded RAM (addr[7:0]), start_save with sv_ready random → sv_data sequence is 0..255,0..255. sv_data is stable whenever stalled. One done pulse after the 512th accept.
- start_load and start_save in the same cycle → LOAD entered. Then start_save during LOAD → ignored.
- abort after 100 load bytes while ld_valid=1 → addresses 0..99 written, addr 100 keeps its prior value. IDLE next cycle. No done pulse.
- rst_n pulsed low mid-SAVE → sv_valid=0 immediately. INIT refills all 512 bytes with 8'hFF. Then start_save returns only 8'hFF.
